// File: rtl/axi_adcfifo_capture_seq_if.sv
// Bus bundle between the capture sequencer and its control/data-path peers.
// The sequencer takes the slave modport; the block driving requests,
// triggers and beat strobes takes the master modport.
interface axi_adcfifo_capture_seq_if #(
    parameter int CNT_W  = 20,
    parameter int TIMO_W = 24
);
    logic              xfer_req;
    logic              dac_txed;
    logic              meas_noise;
    logic              abort;
    logic [CNT_W-1:0]  cfg_num_beats;
    logic [TIMO_W-1:0] cfg_timo;
    logic              adc_dwr;
    logic              adc_en;
    logic              fifo_wr;
    logic              fifo_init;
    logic              busy;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  beat_cnt;
    logic [3:0]        trig_cnt;
    logic              timo_flag;

    modport master (
        output xfer_req, dac_txed, meas_noise, abort, cfg_num_beats, cfg_timo, adc_dwr,
        input  adc_en, fifo_wr, fifo_init, busy, state_o, beat_cnt, trig_cnt, timo_flag
    );

    modport slave (
        input  xfer_req, dac_txed, meas_noise, abort, cfg_num_beats, cfg_timo, adc_dwr,
        output adc_en, fifo_wr, fifo_init, busy, state_o, beat_cnt, trig_cnt, timo_flag
    );
endinterface

// File: rtl/axi_adcfifo_capture_seq.sv
// ADC capture sequencer (adc_clk domain): arms on a DMA request edge, waits
// for a DAC-transmit edge (or noise-mode level), opens the capture window for
// a programmed number of wide beats, and reports status for register readback.
module axi_adcfifo_capture_seq #(
    parameter int CNT_W  = 20,
    parameter int TIMO_W = 24
) (
    input logic                      adc_clk,
    input logic                      adc_rst,
    axi_adcfifo_capture_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              xfer_req_dly_q, dac_txed_dly_q;
    logic              adc_en_q, fifo_init_q, busy_q, timo_flag_q;
    logic [CNT_W-1:0]  beat_cnt_q, beats_sh_q;
    logic [TIMO_W-1:0] timo_cnt_q, timo_sh_q;
    logic [3:0]        trig_cnt_q;

    logic req_edge, trig, timeout_hit, last_beat;
    logic arm, start, timo_set;

    // State register
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        req_edge    = bus.xfer_req & ~xfer_req_dly_q;
        trig        = (bus.dac_txed & ~dac_txed_dly_q) | bus.meas_noise;
        timeout_hit = (timo_sh_q != '0) && (timo_cnt_q == timo_sh_q);
        last_beat   = bus.adc_dwr && (beats_sh_q != '0) &&
                      (beat_cnt_q == beats_sh_q - CNT_W'(1));
        state_d     = state_q;
        arm         = 1'b0;
        start       = 1'b0;
        timo_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_edge) begin
                    state_d = S_ARMED;
                    arm     = 1'b1;
                end
            end
            S_ARMED: begin
                if (trig) begin
                    state_d = S_CAPTURE;
                    start   = 1'b1;
                end else if (timeout_hit) begin
                    state_d  = S_IDLE;
                    timo_set = 1'b1;
                end else if (!bus.xfer_req) begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (beats_sh_q != '0) begin
                    if (last_beat) state_d = S_DONE;
                end else if (!bus.xfer_req) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.xfer_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d  = S_IDLE;
            arm      = 1'b0;
            start    = 1'b0;
            timo_set = 1'b0;
        end
    end

    // Edge history, capture window, shadow config, counters and sticky flag
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            xfer_req_dly_q <= 1'b0;
            dac_txed_dly_q <= 1'b0;
            adc_en_q       <= 1'b0;
            fifo_init_q    <= 1'b0;
            busy_q         <= 1'b0;
            timo_flag_q    <= 1'b0;
            beat_cnt_q     <= '0;
            beats_sh_q     <= '0;
            timo_cnt_q     <= '0;
            timo_sh_q      <= '0;
            trig_cnt_q     <= '0;
        end else begin
            xfer_req_dly_q <= bus.xfer_req;
            dac_txed_dly_q <= bus.dac_txed;
            adc_en_q       <= (state_d == S_CAPTURE);
            fifo_init_q    <= start;
            busy_q         <= (state_d != S_IDLE);
            if (arm) begin
                beats_sh_q  <= bus.cfg_num_beats;
                timo_sh_q   <= bus.cfg_timo;
                beat_cnt_q  <= '0;
                timo_cnt_q  <= '0;
                timo_flag_q <= 1'b0;
            end else begin
                if (state_q == S_ARMED) begin
                    timo_cnt_q <= timo_cnt_q + TIMO_W'(1);
                end
                // A beat coincident with abort is still written, so it is counted too
                if ((state_q == S_CAPTURE) && bus.adc_dwr && (beat_cnt_q != '1)) begin
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                end
                if (timo_set) begin
                    timo_flag_q <= 1'b1;
                end
            end
            if (start) begin
                trig_cnt_q <= trig_cnt_q + 4'd1;
            end
        end
    end

    // Output drive
    always_comb begin
        bus.adc_en    = adc_en_q;
        bus.fifo_wr   = bus.adc_dwr & adc_en_q;
        bus.fifo_init = fifo_init_q;
        bus.busy      = busy_q;
        bus.state_o   = state_q;
        bus.beat_cnt  = beat_cnt_q;
        bus.trig_cnt  = trig_cnt_q;
        bus.timo_flag = timo_flag_q;
    end

endmodule

// File: tb/tb_axi_adcfifo_capture_seq.sv
// Scoreboard bench for the capture sequencer: stimulus pushes the cycles at
// which fifo_wr / fifo_init must appear, a negedge monitor pops and compares.
module tb_axi_adcfifo_capture_seq;

    localparam int CNT_W  = 20;
    localparam int TIMO_W = 24;
    localparam int BIG    = 32'h4000_0000;

    logic adc_clk = 1'b0;
    logic adc_rst;

    axi_adcfifo_capture_seq_if #(.CNT_W(CNT_W), .TIMO_W(TIMO_W)) bus ();

    axi_adcfifo_capture_seq #(.CNT_W(CNT_W), .TIMO_W(TIMO_W)) dut (
        .adc_clk (adc_clk),
        .adc_rst (adc_rst),
        .bus     (bus)
    );

    always #5 adc_clk = ~adc_clk;

    int cyc = 0;
    always @(posedge adc_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int exp_wr[$];
    int exp_init[$];
    bit mon_en = 1'b0;

    // Reference: a beat is written iff its strobe falls in [open_from, open_until]
    // and fewer than n_limit beats (0 = unlimited) were written so far.
    int open_from  = BIG;
    int open_until = BIG;
    int n_limit    = 0;
    int n_written  = 0;
    int exp_trig   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit rbit();
        return ($urandom_range(0, 1) != 0);
    endfunction

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic strobe(input bit d);
        bus.adc_dwr = d;
        if (d && cyc >= open_from && cyc <= open_until &&
            (n_limit == 0 || n_written < n_limit)) begin
            exp_wr.push_back(cyc);
            n_written++;
        end
    endtask

    task automatic trigger_now();
        bus.dac_txed = 1'b1;
        exp_init.push_back(cyc + 1);
        open_from = cyc + 1;
        exp_trig  = (exp_trig + 1) % 16;
    endtask

    task automatic idle(input int n);
        open_from  = BIG;
        open_until = BIG;
        bus.xfer_req = 1'b0;
        bus.abort    = 1'b0;
        for (int i = 0; i < n; i++) begin
            strobe(rbit());
            tick();
        end
    endtask

    task automatic drained(input string tag);
        chk({tag, "_wr_drained"}, exp_wr.size(), 0);
        chk({tag, "_init_drained"}, exp_init.size(), 0);
    endtask

    // Monitor: every fifo_wr / fifo_init must match the next expected cycle
    always @(negedge adc_clk) begin
        if (mon_en) begin
            if (bus.fifo_wr) begin
                if (exp_wr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_fifo_wr: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("fifo_wr_cycle", cyc, exp_wr.pop_front());
                end
            end
            if (bus.fifo_init) begin
                if (exp_init.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_fifo_init: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("fifo_init_cycle", cyc, exp_init.pop_front());
                end
            end
        end
    end

    task automatic capture(input int n, input int delay, input int period,
                           input bit pre_high, input bit toggle_req);
        int guard;
        idle(3);
        bus.cfg_num_beats = CNT_W'(n);
        bus.cfg_timo      = '0;
        bus.meas_noise    = 1'b0;
        bus.dac_txed      = pre_high;
        n_limit   = n;
        n_written = 0;
        if (pre_high) begin strobe(0); tick(); end
        bus.xfer_req = 1'b1;
        strobe(rbit());
        tick();
        bus.cfg_num_beats = CNT_W'(n + 3);
        bus.cfg_timo      = TIMO_W'(2);
        chk("arm_state", int'(bus.state_o), 1);
        chk("arm_flag_clear", int'(bus.timo_flag), 0);
        for (int i = 1; i < delay; i++) begin
            if (pre_high && i == delay - 2) bus.dac_txed = 1'b0;
            strobe(cyc % period == 0);
            tick();
        end
        chk("pre_trig_state", int'(bus.state_o), 1);
        trigger_now();
        strobe(cyc % period == 0);
        tick();
        chk("cap_adc_en", int'(bus.adc_en), 1);
        chk("cap_state", int'(bus.state_o), 2);
        guard = 0;
        while (n_written < n && guard < 400) begin
            if (toggle_req && guard == 2) begin bus.xfer_req = 1'b0; bus.dac_txed = 1'b0; end
            if (toggle_req && guard == 3) begin bus.xfer_req = 1'b1; bus.dac_txed = 1'b1; end
            strobe(cyc % period == 0);
            tick();
            guard++;
        end
        if (guard >= 400) begin
            checks++; failures++;
            $display("FAIL capture_budget: got %0d beats expected %0d", n_written, n);
        end
        for (int i = 0; i < 3; i++) begin
            strobe(1);
            tick();
        end
        chk("done_state", int'(bus.state_o), 3);
        chk("done_adc_en", int'(bus.adc_en), 0);
        chk("done_busy", int'(bus.busy), 1);
        chk("done_beat_cnt", int'(bus.beat_cnt), n);
        chk("done_trig_cnt", int'(bus.trig_cnt), exp_trig);
        bus.xfer_req = 1'b0;
        strobe(0);
        tick();
        chk("post_idle_state", int'(bus.state_o), 0);
        chk("post_idle_busy", int'(bus.busy), 0);
        chk("beat_cnt_hold", int'(bus.beat_cnt), n);
        bus.dac_txed = 1'b0;
        drained("capture");
    endtask

    task automatic timeout_run(input int t);
        idle(3);
        bus.cfg_timo      = TIMO_W'(t);
        bus.cfg_num_beats = CNT_W'(4);
        n_limit   = 4;
        n_written = 0;
        bus.xfer_req = 1'b1;
        strobe(rbit());
        tick();
        bus.cfg_timo = '0;
        for (int k = 0; k < t; k++) begin
            strobe(rbit());
            tick();
        end
        chk("timo_still_armed", int'(bus.state_o), 1);
        chk("timo_flag_before", int'(bus.timo_flag), 0);
        strobe(rbit());
        tick();
        chk("timo_idle", int'(bus.state_o), 0);
        chk("timo_flag_set", int'(bus.timo_flag), 1);
        chk("timo_adc_en", int'(bus.adc_en), 0);
        bus.xfer_req = 1'b0;
        tick();
        chk("timo_flag_sticky", int'(bus.timo_flag), 1);
        bus.xfer_req = 1'b1;
        tick();
        chk("rearm_state", int'(bus.state_o), 1);
        chk("rearm_flag_clear", int'(bus.timo_flag), 0);
        bus.xfer_req = 1'b0;
        tick();
        chk("withdraw_idle", int'(bus.state_o), 0);
        chk("withdraw_no_flag", int'(bus.timo_flag), 0);
        drained("timeout");
    endtask

    task automatic tie_run(input int t, input bit late);
        int guard;
        idle(3);
        bus.cfg_timo      = TIMO_W'(t);
        bus.cfg_num_beats = CNT_W'(2);
        n_limit   = 2;
        n_written = 0;
        bus.xfer_req = 1'b1;
        strobe(0);
        tick();
        for (int k = 0; k < t; k++) begin
            strobe(rbit());
            tick();
        end
        if (!late) begin
            trigger_now();
            strobe(0);
            tick();
            chk("tie_capture", int'(bus.state_o), 2);
            chk("tie_flag", int'(bus.timo_flag), 0);
            guard = 0;
            while (n_written < 2 && guard < 50) begin
                strobe(1);
                tick();
                guard++;
            end
            strobe(0);
            tick();
            chk("tie_done", int'(bus.state_o), 3);
        end else begin
            strobe(0);
            tick();
            chk("late_idle", int'(bus.state_o), 0);
            chk("late_flag", int'(bus.timo_flag), 1);
            bus.dac_txed = 1'b1;
            strobe(1);
            tick();
            chk("late_trig_ignored", int'(bus.state_o), 0);
        end
        bus.xfer_req = 1'b0;
        tick();
        bus.dac_txed = 1'b0;
        chk("tie_end_idle", int'(bus.state_o), 0);
        drained("tie");
    endtask

    task automatic noise_run(input int len);
        idle(3);
        bus.meas_noise    = 1'b1;
        bus.cfg_num_beats = '0;
        bus.cfg_timo      = '0;
        n_limit   = 0;
        n_written = 0;
        bus.xfer_req = 1'b1;
        strobe(rbit());
        tick();
        chk("noise_armed", int'(bus.state_o), 1);
        exp_init.push_back(cyc + 1);
        open_from = cyc + 1;
        exp_trig  = (exp_trig + 1) % 16;
        strobe(rbit());
        tick();
        chk("noise_capture", int'(bus.state_o), 2);
        chk("noise_adc_en", int'(bus.adc_en), 1);
        for (int i = 0; i < len; i++) begin
            strobe(rbit());
            tick();
        end
        chk("noise_still_capture", int'(bus.state_o), 2);
        bus.xfer_req = 1'b0;
        open_until = cyc;
        strobe(rbit());
        tick();
        chk("noise_done", int'(bus.state_o), 3);
        chk("noise_done_adc_en", int'(bus.adc_en), 0);
        chk("noise_beat_cnt", int'(bus.beat_cnt), n_written);
        strobe(1);
        tick();
        chk("noise_idle", int'(bus.state_o), 0);
        chk("noise_trig_cnt", int'(bus.trig_cnt), exp_trig);
        bus.meas_noise = 1'b0;
        drained("noise");
    endtask

    task automatic abort_run(input bit use_rst);
        int guard;
        idle(3);
        bus.cfg_num_beats = CNT_W'(8);
        bus.cfg_timo      = '0;
        n_limit   = 8;
        n_written = 0;
        bus.xfer_req = 1'b1;
        strobe(rbit());
        tick();
        for (int i = 0; i < 3; i++) begin
            strobe(rbit());
            tick();
        end
        trigger_now();
        strobe(rbit());
        tick();
        guard = 0;
        while (n_written < 3 && guard < 200) begin
            strobe(rbit());
            tick();
            guard++;
        end
        if (use_rst) begin
            adc_rst      = 1'b1;
            bus.xfer_req = 1'b0;
        end else begin
            bus.abort = 1'b1;
        end
        open_until = cyc;
        strobe(rbit());
        tick();
        bus.dac_txed = 1'b0;
        if (use_rst) begin
            exp_trig = 0;
            chk("rst_adc_en", int'(bus.adc_en), 0);
            chk("rst_fifo_init", int'(bus.fifo_init), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_state", int'(bus.state_o), 0);
            chk("rst_beat_cnt", int'(bus.beat_cnt), 0);
            chk("rst_trig_cnt", int'(bus.trig_cnt), 0);
            chk("rst_timo_flag", int'(bus.timo_flag), 0);
            adc_rst = 1'b0;
        end else begin
            chk("abort_adc_en", int'(bus.adc_en), 0);
            chk("abort_state", int'(bus.state_o), 0);
            chk("abort_busy", int'(bus.busy), 0);
            chk("abort_beat_cnt", int'(bus.beat_cnt), n_written);
            bus.abort = 1'b0;
            strobe(1);
            tick();
            chk("abort_no_rearm", int'(bus.state_o), 0);
        end
        bus.xfer_req = 1'b0;
        strobe(0);
        tick();
        drained(use_rst ? "reset" : "abort");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        adc_rst           = 1'b1;
        bus.xfer_req      = 1'b0;
        bus.dac_txed      = 1'b0;
        bus.meas_noise    = 1'b0;
        bus.abort         = 1'b0;
        bus.cfg_num_beats = '0;
        bus.cfg_timo      = '0;
        bus.adc_dwr       = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        chk("reset_state", int'(bus.state_o), 0);
        chk("reset_adc_en", int'(bus.adc_en), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_beat_cnt", int'(bus.beat_cnt), 0);
        chk("reset_trig_cnt", int'(bus.trig_cnt), 0);
        chk("reset_timo_flag", int'(bus.timo_flag), 0);
        adc_rst = 1'b0;

        capture(8, 5, 4, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            capture(int'($urandom_range(1, 12)), int'($urandom_range(4, 9)),
                    int'($urandom_range(1, 4)), rbit(), 1'b0);
        end
        timeout_run(100);
        timeout_run(int'($urandom_range(1, 30)));
        tie_run(10, 1'b0);
        tie_run(10, 1'b1);
        noise_run(int'($urandom_range(5, 20)));
        abort_run(1'b0);
        abort_run(1'b0);
        abort_run(1'b1);
        capture(6, 4, 2, 1'b0, 1'b1);
        for (int r = 0; r < 12; r++) begin
            capture(1, 4, 1, 1'b0, 1'b0);
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
